calc_seq: RTL

Parametrised, multi-cycle arithmetic unit with valid/ready handshakes. It performs add, subtract, multiply and divide on two WIDTH-bit unsigned operands. Multiply and divide are iterative, one bit per clock, instead of single-cycle combinational logic. It sits between an operand source and a result consumer, and can absorb back-pressure on its output.

---
 rtl/calc_seq_if.sv | 24 ++
 rtl/calc_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/calc_seq_if.sv
// Command/result handshake bundle for calc_seq: operands and op in, result and div_zero out.
interface calc_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [1:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               div_zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, div_zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, div_zero
  );
endinterface

// File: rtl/calc_seq.sv
// Multi-cycle unsigned add/sub/mul/div unit; mul and div resolve one bit per clock.
// state | meaning
// IDLE  | ready for a command, in_ready high unless rst
// BUSY  | WIDTH shift-add or restoring-divide iterations in progress
// DONE  | result presented, held until out_ready
module calc_seq #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  calc_seq_if.slave bus
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [RW-1:0]   a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   result_q, result_d;
  logic            div_zero_q, div_zero_d;

  logic [RW-1:0]   a_ext, b_ext;
  logic [RW-1:0]   acc_n, a_n;
  logic [WIDTH:0]  shifted;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.div_zero  = div_zero_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    a_ext      = RW'(bus.a);
    b_ext      = RW'(bus.b);
    acc_n      = acc_q;
    a_n        = a_q;
    shifted    = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d  = bus.op;
          a_d   = a_ext;
          b_d   = bus.b;
          acc_d = '0;
          cnt_d = CW'(WIDTH - 1);
          if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0)) begin
            state_d = BUSY;
          end else begin
            state_d    = DONE;
            div_zero_d = 1'b0;
            case (bus.op)
              OP_ADD:  result_d = a_ext + b_ext;
              OP_SUB:  result_d = a_ext - b_ext;
              default: begin
                result_d   = '0;
                div_zero_d = 1'b1;
              end
            endcase
          end
        end
      end

      BUSY: begin
        if (op_q == OP_MUL) begin
          acc_n = b_q[0] ? acc_q + a_q : acc_q;
          a_n   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          // a_q low half shifts dividend bits out and quotient bits in
          if (shifted >= {1'b0, b_q}) begin
            acc_n = RW'(shifted - {1'b0, b_q});
            a_n   = {a_q[RW-2:0], 1'b1};
          end else begin
            acc_n = RW'(shifted);
            a_n   = {a_q[RW-2:0], 1'b0};
          end
        end
        acc_d = acc_n;
        a_d   = a_n;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d    = DONE;
          div_zero_d = 1'b0;
          result_d   = (op_q == OP_MUL) ? acc_n : {acc_n[WIDTH-1:0], a_n[WIDTH-1:0]};
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end
endmodule
